// File: rtl/mmu_bus_arbiter_if.sv
// Requester, main-bus and high-bus signals around the memory bus arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mmu_bus_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic        cpu_blocked;

  logic        oam_active;
  logic [15:0] oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_read_en;
  logic        oam_write_en;
  logic [7:0]  oam_rdata;
  logic        oam_grant;

  logic        hdma_req;
  logic [15:0] hdma_addr;
  logic [7:0]  hdma_wdata;
  logic        hdma_read_en;
  logic        hdma_write_en;
  logic [7:0]  hdma_rdata;
  logic        hdma_grant;

  logic [15:0] main_addr;
  logic [7:0]  main_wdata;
  logic        main_read_en;
  logic        main_write_en;
  logic [7:0]  main_rdata;

  logic [15:0] high_addr;
  logic [7:0]  high_wdata;
  logic        high_read_en;
  logic        high_write_en;
  logic [7:0]  high_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read_en, cpu_write_en,
    output cpu_rdata, cpu_stall, cpu_blocked,
    input  oam_active, oam_addr, oam_wdata, oam_read_en, oam_write_en,
    output oam_rdata, oam_grant,
    input  hdma_req, hdma_addr, hdma_wdata, hdma_read_en, hdma_write_en,
    output hdma_rdata, hdma_grant,
    output main_addr, main_wdata, main_read_en, main_write_en,
    input  main_rdata,
    output high_addr, high_wdata, high_read_en, high_write_en,
    input  high_rdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read_en, cpu_write_en,
    input  cpu_rdata, cpu_stall, cpu_blocked,
    output oam_active, oam_addr, oam_wdata, oam_read_en, oam_write_en,
    input  oam_rdata, oam_grant,
    output hdma_req, hdma_addr, hdma_wdata, hdma_read_en, hdma_write_en,
    input  hdma_rdata, hdma_grant,
    input  main_addr, main_wdata, main_read_en, main_write_en,
    output main_rdata,
    input  high_addr, high_wdata, high_read_en, high_write_en,
    output high_rdata
  );
endinterface

// File: rtl/mmu_bus_arbiter.sv
// Arbitrates the main memory bus between CPU, OAM DMA and HDMA; CPU high-page
// accesses bypass arbitration on a dedicated high bus.
module mmu_bus_arbiter #(
  parameter logic [15:0] HIGH_BASE = 16'hFF00,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  mmu_bus_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_CPU  = 2'd0;
  localparam logic [1:0] OWN_OAM  = 2'd1;
  localparam logic [1:0] OWN_HDMA = 2'd2;

  logic [1:0] owner_reg;
  logic [1:0] owner_next;
  logic [1:0] pending;
  logic       owner_busy;
  logic       cpu_high;
  logic       cpu_main_acc;
  logic       cpu_hold;
  logic       cpu_fwd;

  assign cpu_high     = (bus.cpu_addr >= HIGH_BASE);
  assign cpu_main_acc = (bus.cpu_read_en | bus.cpu_write_en) & ~cpu_high;
  assign cpu_hold     = cpu_main_acc & (bus.hdma_req | (owner_reg == OWN_HDMA));
  // A CPU access held off by a pending HDMA never reaches the bus, so it must
  // not keep the CPU owner busy, otherwise the stalled CPU would deadlock HDMA.
  assign cpu_fwd      = cpu_main_acc & (owner_reg == OWN_CPU) & ~bus.hdma_req;

  always_comb begin
    if (bus.hdma_req)
      pending = OWN_HDMA;
    else if (bus.oam_active)
      pending = OWN_OAM;
    else
      pending = OWN_CPU;
  end

  always_comb begin
    case (owner_reg)
      OWN_OAM:  owner_busy = bus.oam_read_en | bus.oam_write_en;
      OWN_HDMA: owner_busy = bus.hdma_read_en | bus.hdma_write_en;
      default:  owner_busy = cpu_fwd;
    endcase
  end

  // Every state's idle-boundary transition resolves to the pending owner.
  assign owner_next = owner_busy ? owner_reg : pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      owner_reg <= OWN_CPU;
    else
      owner_reg <= owner_next;
  end

  always_comb begin
    bus.main_addr     = 16'h0000;
    bus.main_wdata    = 8'h00;
    bus.main_read_en  = 1'b0;
    bus.main_write_en = 1'b0;
    bus.high_addr     = 16'h0000;
    bus.high_wdata    = 8'h00;
    bus.high_read_en  = 1'b0;
    bus.high_write_en = 1'b0;
    bus.cpu_rdata     = OPEN_BUS;
    bus.cpu_stall     = 1'b0;
    bus.cpu_blocked   = 1'b0;
    bus.oam_rdata     = OPEN_BUS;
    bus.hdma_rdata    = OPEN_BUS;
    bus.oam_grant     = 1'b0;
    bus.hdma_grant    = 1'b0;
    // Reset gates every output so an in-flight strobe dies immediately.
    if (!reset) begin
      bus.oam_rdata   = bus.main_rdata;
      bus.hdma_rdata  = bus.main_rdata;
      bus.oam_grant   = (owner_reg == OWN_OAM);
      bus.hdma_grant  = (owner_reg == OWN_HDMA);
      bus.cpu_stall   = (owner_reg == OWN_HDMA) | cpu_hold;
      bus.cpu_blocked = (owner_reg == OWN_OAM) & cpu_main_acc & ~cpu_hold;
      if (cpu_high) begin
        bus.high_addr     = bus.cpu_addr;
        bus.high_wdata    = bus.cpu_wdata;
        bus.high_read_en  = bus.cpu_read_en;
        bus.high_write_en = bus.cpu_write_en;
        bus.cpu_rdata     = bus.high_rdata;
      end
      case (owner_reg)
        OWN_OAM: begin
          bus.main_addr     = bus.oam_addr;
          bus.main_wdata    = bus.oam_wdata;
          bus.main_read_en  = bus.oam_read_en;
          bus.main_write_en = bus.oam_write_en;
        end
        OWN_HDMA: begin
          bus.main_addr     = bus.hdma_addr;
          bus.main_wdata    = bus.hdma_wdata;
          bus.main_read_en  = bus.hdma_read_en;
          bus.main_write_en = bus.hdma_write_en;
        end
        default: begin
          if (cpu_fwd) begin
            bus.main_addr     = bus.cpu_addr;
            bus.main_wdata    = bus.cpu_wdata;
            bus.main_read_en  = bus.cpu_read_en;
            bus.main_write_en = bus.cpu_write_en;
            if (bus.cpu_read_en)
              bus.cpu_rdata = bus.main_rdata;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Directed bench for mmu_bus_arbiter: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mmu_bus_arbiter;

  localparam int S_MADDR  = 0;
  localparam int S_MRD    = 1;
  localparam int S_MWR    = 2;
  localparam int S_CRDATA = 3;
  localparam int S_STALL  = 4;
  localparam int S_BLOCK  = 5;
  localparam int S_OGNT   = 6;
  localparam int S_HGNT   = 7;
  localparam int S_HWR    = 8;
  localparam int S_MWDATA = 9;
  localparam int S_ORDATA = 10;
  localparam int S_HADDR  = 11;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic stim_done = 1'b0;
  logic mem_ready = 1'b0;
  exp_t sb[$];

  logic [7:0] main_mem [4096];
  logic [7:0] high_mem [256];

  mmu_bus_arbiter_if bus ();

  mmu_bus_arbiter #(
    .HIGH_BASE(16'hFF00),
    .OPEN_BUS (8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models behind both buses; unwritten main locations hold index^A5.
  assign bus.main_rdata = main_mem[bus.main_addr[11:0]];
  assign bus.high_rdata = high_mem[bus.high_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) main_mem[i] <= 8'(i) ^ 8'hA5;
      for (int i = 0; i < 256; i++) high_mem[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (bus.main_write_en) main_mem[bus.main_addr[11:0]] <= bus.main_wdata;
      if (bus.high_write_en) high_mem[bus.high_addr[7:0]] <= bus.high_wdata;
    end
  end

  function automatic logic [15:0] sel(int s);
    case (s)
      S_MADDR:  return bus.main_addr;
      S_MRD:    return {15'd0, bus.main_read_en};
      S_MWR:    return {15'd0, bus.main_write_en};
      S_CRDATA: return {8'd0, bus.cpu_rdata};
      S_STALL:  return {15'd0, bus.cpu_stall};
      S_BLOCK:  return {15'd0, bus.cpu_blocked};
      S_OGNT:   return {15'd0, bus.oam_grant};
      S_HGNT:   return {15'd0, bus.hdma_grant};
      S_HWR:    return {15'd0, bus.high_write_en};
      S_MWDATA: return {8'd0, bus.main_wdata};
      S_ORDATA: return {8'd0, bus.oam_rdata};
      S_HADDR:  return bus.high_addr;
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_sig(input string name, input int sig, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
    bus.cpu_read_en = 1'b0;  bus.cpu_write_en = 1'b0;
    bus.oam_active = 1'b0;   bus.oam_addr = 16'h0000; bus.oam_wdata = 8'h00;
    bus.oam_read_en = 1'b0;  bus.oam_write_en = 1'b0;
    bus.hdma_req = 1'b0;     bus.hdma_addr = 16'h0000; bus.hdma_wdata = 8'h00;
    bus.hdma_read_en = 1'b0; bus.hdma_write_en = 1'b0;
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = sel(e.sig);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %h, expected %h", e.name, cyc, act, e.val);
      end else begin
        $display("check %s @cyc %0d: %h ok", e.name, cyc, act);
      end
    end
    if (stim_done) begin
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_all();
    reset = 1'b1;
    step();
    step();
    expect_sig("rst_cpu_rdata", S_CRDATA, 16'h00FF);
    expect_sig("rst_oam_rdata", S_ORDATA, 16'h00FF);
    expect_sig("rst_main_wr", S_MWR, 16'h0);
    expect_sig("rst_stall", S_STALL, 16'h0);
    expect_sig("rst_oam_grant", S_OGNT, 16'h0);
    expect_sig("rst_hdma_grant", S_HGNT, 16'h0);
    expect_sig("rst_blocked", S_BLOCK, 16'h0);
    step();
    reset = 1'b0;

    // CPU only: write then read back 0xC000.
    bus.cpu_addr = 16'hC000; bus.cpu_wdata = 8'h5A; bus.cpu_write_en = 1'b1;
    expect_sig("cpu_wr_main_wr", S_MWR, 16'h1);
    expect_sig("cpu_wr_main_addr", S_MADDR, 16'hC000);
    expect_sig("cpu_wr_stall", S_STALL, 16'h0);
    expect_sig("cpu_wr_oam_grant", S_OGNT, 16'h0);
    expect_sig("cpu_wr_hdma_grant", S_HGNT, 16'h0);
    step();
    bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b1;
    expect_sig("cpu_rd_data", S_CRDATA, 16'h005A);
    expect_sig("cpu_rd_main_rd", S_MRD, 16'h1);
    expect_sig("cpu_rd_stall", S_STALL, 16'h0);
    step();
    bus.cpu_read_en = 1'b0;
    expect_sig("idle_main_addr", S_MADDR, 16'h0000);
    expect_sig("idle_main_rd", S_MRD, 16'h0);

    // OAM request: granted one clock later; CPU main reads are blocked.
    bus.oam_active = 1'b1; bus.oam_addr = 16'hC13C;
    expect_sig("oam_req_latency", S_OGNT, 16'h0);
    step();
    expect_sig("oam_granted", S_OGNT, 16'h1);
    bus.cpu_addr = 16'hC000; bus.cpu_read_en = 1'b1; bus.oam_read_en = 1'b1;
    expect_sig("blk_cpu_rdata", S_CRDATA, 16'h00FF);
    expect_sig("blk_pulse", S_BLOCK, 16'h1);
    expect_sig("blk_main_addr", S_MADDR, 16'hC13C);
    expect_sig("blk_main_rd", S_MRD, 16'h1);
    expect_sig("blk_oam_rdata", S_ORDATA, 16'h0099);
    step();
    bus.cpu_read_en = 1'b0; bus.oam_read_en = 1'b0;
    bus.cpu_addr = 16'hFF80; bus.cpu_wdata = 8'h33; bus.cpu_write_en = 1'b1;
    expect_sig("hi_wr_en", S_HWR, 16'h1);
    expect_sig("hi_wr_addr", S_HADDR, 16'hFF80);
    expect_sig("hi_wr_blocked", S_BLOCK, 16'h0);
    expect_sig("hi_wr_main_wr", S_MWR, 16'h0);
    expect_sig("hi_wr_stall", S_STALL, 16'h0);
    step();
    bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b1;
    expect_sig("hi_rd_data", S_CRDATA, 16'h0033);
    step();
    bus.cpu_read_en = 1'b0;

    // OAM T1-T4 loop: grant holds through strobe-free cycles.
    for (int i = 0; i < 160; i++) begin
      bus.oam_addr = 16'hC100 + 16'(i); bus.oam_read_en = 1'b1; bus.oam_write_en = 1'b0;
      expect_sig("oam_t1_grant", S_OGNT, 16'h1);
      step();
      bus.oam_read_en = 1'b0; bus.oam_write_en = 1'b1;
      bus.oam_addr = 16'hFE00 + 16'(i); bus.oam_wdata = 8'(i);
      expect_sig("oam_t2_main_wr", S_MWR, 16'h1);
      step();
      bus.oam_write_en = 1'b0;
      expect_sig("oam_t3_grant", S_OGNT, 16'h1);
      step();
      step();
    end
    bus.oam_active = 1'b0;
    expect_sig("oam_release_latency", S_OGNT, 16'h1);
    step();
    expect_sig("oam_released", S_OGNT, 16'h0);
    bus.cpu_addr = 16'hC000; bus.cpu_read_en = 1'b1;
    expect_sig("post_oam_cpu_rdata", S_CRDATA, 16'h005A);
    expect_sig("post_oam_main_rd", S_MRD, 16'h1);
    expect_sig("post_oam_blocked", S_BLOCK, 16'h0);
    step();
    bus.cpu_read_en = 1'b0;

    // HDMA preempts OAM at the first strobe-free cycle.
    bus.oam_active = 1'b1;
    step();
    bus.oam_addr = 16'hC100; bus.oam_read_en = 1'b1;
    expect_sig("pre_t1_grant", S_OGNT, 16'h1);
    step();
    bus.oam_read_en = 1'b0; bus.oam_write_en = 1'b1; bus.oam_addr = 16'hFE00;
    bus.hdma_req = 1'b1; bus.hdma_addr = 16'h8800;
    expect_sig("pre_t2_oam_grant", S_OGNT, 16'h1);
    expect_sig("pre_t2_hdma_grant", S_HGNT, 16'h0);
    expect_sig("pre_t2_main_wr", S_MWR, 16'h1);
    expect_sig("pre_t2_main_addr", S_MADDR, 16'hFE00);
    step();
    bus.oam_write_en = 1'b0;
    bus.cpu_addr = 16'hC000; bus.cpu_read_en = 1'b1;
    expect_sig("pre_t3_oam_grant", S_OGNT, 16'h1);
    expect_sig("pre_t3_hdma_grant", S_HGNT, 16'h0);
    expect_sig("pre_t3_cpu_stall", S_STALL, 16'h1);
    expect_sig("pre_t3_blocked", S_BLOCK, 16'h0);
    expect_sig("pre_t3_main_rd", S_MRD, 16'h0);
    step();
    bus.oam_read_en = 1'b1;
    bus.hdma_write_en = 1'b1; bus.hdma_wdata = 8'h77;
    expect_sig("hdma_grant", S_HGNT, 16'h1);
    expect_sig("hdma_oam_grant", S_OGNT, 16'h0);
    expect_sig("hdma_main_wr", S_MWR, 16'h1);
    expect_sig("hdma_main_wdata", S_MWDATA, 16'h0077);
    expect_sig("hdma_main_addr", S_MADDR, 16'h8800);
    expect_sig("hdma_ignores_oam_rd", S_MRD, 16'h0);
    expect_sig("hdma_cpu_stall", S_STALL, 16'h1);
    step();
    bus.oam_read_en = 1'b0; bus.hdma_write_en = 1'b0;
    bus.cpu_addr = 16'hFF44;
    expect_sig("hdma_hi_stall", S_STALL, 16'h1);
    expect_sig("hdma_hi_addr", S_HADDR, 16'hFF44);
    expect_sig("hdma_hi_rdata", S_CRDATA, 16'h0000);
    step();
    bus.hdma_req = 1'b0; bus.cpu_read_en = 1'b0;
    expect_sig("hdma_release_latency", S_HGNT, 16'h1);
    expect_sig("hdma_release_stall", S_STALL, 16'h1);
    step();
    expect_sig("oam_regain", S_OGNT, 16'h1);
    expect_sig("oam_regain_hdma", S_HGNT, 16'h0);
    expect_sig("oam_regain_stall", S_STALL, 16'h0);
    bus.oam_active = 1'b0;
    step();
    expect_sig("oam_done", S_OGNT, 16'h0);

    // Simultaneous requests from idle: HDMA first, OAM after HDMA drops.
    bus.hdma_req = 1'b1; bus.oam_active = 1'b1;
    expect_sig("sim_hdma_latency", S_HGNT, 16'h0);
    expect_sig("sim_oam_latency", S_OGNT, 16'h0);
    step();
    expect_sig("sim_hdma_first", S_HGNT, 16'h1);
    expect_sig("sim_oam_wait", S_OGNT, 16'h0);
    step();
    bus.hdma_req = 1'b0;
    expect_sig("sim_hdma_hold", S_HGNT, 16'h1);
    expect_sig("sim_oam_still_wait", S_OGNT, 16'h0);
    step();
    expect_sig("sim_oam_granted", S_OGNT, 16'h1);
    expect_sig("sim_hdma_dropped", S_HGNT, 16'h0);
    bus.oam_active = 1'b0;
    step();
    expect_sig("sim_oam_done", S_OGNT, 16'h0);

    // Async reset in the middle of an HDMA write.
    bus.hdma_req = 1'b1;
    step();
    bus.hdma_addr = 16'h8801; bus.hdma_wdata = 8'h99; bus.hdma_write_en = 1'b1;
    expect_sig("rst_pre_hdma_grant", S_HGNT, 16'h1);
    expect_sig("rst_pre_main_wr", S_MWR, 16'h1);
    step();
    bus.hdma_addr = 16'h8802;
    #2;
    reset = 1'b1;
    expect_sig("async_rst_main_wr", S_MWR, 16'h0);
    expect_sig("async_rst_hdma_grant", S_HGNT, 16'h0);
    expect_sig("async_rst_stall", S_STALL, 16'h0);
    step();
    step();
    reset = 1'b0;
    expect_sig("post_rst_stall", S_STALL, 16'h0);
    expect_sig("post_rst_hdma_grant", S_HGNT, 16'h0);
    expect_sig("post_rst_main_wr", S_MWR, 16'h0);
    step();
    expect_sig("post_rst_regrant", S_HGNT, 16'h1);
    expect_sig("post_rst_regrant_stall", S_STALL, 16'h1);
    idle_all();
    step();
    step();
    stim_done = 1'b1;
  end

endmodule
